// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: registered-read instruction memory with a handshake
// load port. The fetch stage reads one word per cycle in RUN; a host can
// stream a program image in through the LOAD state, during which fetch is
// held off. Optional per-word even parity is enabled by defining
// INSTR_MEM_PARITY_EN (the port list is identical in both builds).
module instr_mem_loadable #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  // NOP opcode (4'h0) in the top nibble, zero operand field
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = {4'h0, 24'd0}
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iFetchReq,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oInstrValid,
  output logic                  oParityErr,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadCount,
  input  logic                  iLoadValid,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  input  logic                  iParityFlip,
  output logic                  oLoadReady,
  output logic                  oLoadDone,
  output logic                  oBusy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

  state_t              state;
  logic [MW-1:0]       mem [DEPTH];
  // one bit wider than the address so a full-depth load cannot wrap
  logic [ADDR_WIDTH:0] ptr;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_clamp;
  logic                fetch_in_range;
  logic [IW-1:0]       fetch_idx;
  logic [IW-1:0]       wr_idx;
  logic [MW-1:0]       fetch_word;
  logic [MW-1:0]       wr_word;
  logic                wr_en;
  logic                fetch_perr;

  assign cnt_clamp      = ({1'b0, iLoadCount} > DEPTH_W) ? DEPTH_W : {1'b0, iLoadCount};
  assign fetch_in_range = ({1'b0, iAddress} < DEPTH_W);
  assign fetch_idx      = iAddress[IW-1:0];
  assign wr_idx         = ptr[IW-1:0];
  assign fetch_word     = mem[fetch_idx];
  // a write coinciding with reset is dropped; earlier words survive
  assign wr_en          = Reset && (state == LOAD) && iLoadValid;

`ifdef INSTR_MEM_PARITY_EN
  // even parity: stored bit makes the XOR of the whole word zero
  assign wr_word    = {(^iLoadData) ^ iParityFlip, iLoadData};
  assign fetch_perr = fetch_in_range &&
                      ((^fetch_word[DATA_WIDTH-1:0]) != fetch_word[DATA_WIDTH]);
`else
  logic unused_parity_flip;
  assign unused_parity_flip = iParityFlip;
  assign wr_word    = iLoadData;
  assign fetch_perr = 1'b0;
`endif

  // load-port write into storage (contents are never reset)
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

  // control FSM with registered fetch and load-handshake outputs
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= RUN;
      ptr          <= '0;
      cnt          <= '0;
      oInstruction <= DEFAULT_WORD;
      oInstrValid  <= 1'b0;
      oParityErr   <= 1'b0;
      oLoadReady   <= 1'b0;
      oLoadDone    <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      oInstrValid <= 1'b0;
      oParityErr  <= 1'b0;
      oLoadDone   <= 1'b0;
      unique case (state)
        RUN: begin
          if (iLoadStart) begin
            // load start wins; a same-cycle fetch is dropped
            ptr   <= '0;
            cnt   <= cnt_clamp;
            oBusy <= 1'b1;
            if (cnt_clamp == '0) begin
              state     <= DONE;
              oLoadDone <= 1'b1;
            end else begin
              state      <= LOAD;
              oLoadReady <= 1'b1;
            end
          end else if (iFetchReq) begin
            oInstrValid  <= 1'b1;
            oInstruction <= fetch_in_range ? fetch_word[DATA_WIDTH-1:0] : DEFAULT_WORD;
            oParityErr   <= fetch_perr;
          end
        end
        LOAD: begin
          if (iLoadValid) begin
            ptr <= ptr + 1'b1;
            if (ptr == cnt - 1'b1) begin
              state      <= DONE;
              oLoadReady <= 1'b0;
              oLoadDone  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= RUN;
          oBusy <= 1'b0;
        end
        default: begin
          state      <= RUN;
          oLoadReady <= 1'b0;
          oBusy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, synchronous instruction memory for the course processor. It replaces the fixed combinational program ROM with a registered-read memory of configurable width and depth. A handshake load port lets a host write a program image at runtime. The block sits between the processor's fetch stage (`iAddress`/`oInstruction`) and an external loader (UART or testbench), and holds fetch off while a load is in progress.

## Interface
Parameters:
- `DATA_WIDTH`, 28: instruction word width.
- `ADDR_WIDTH`, 16: width of the fetch address and load count.
- `DEPTH`, 256: number of stored words. Must be ≤ 2^ADDR_WIDTH.
- `DEFAULT_WORD`, {`NOP`, 24'd0}: word returned for out-of-range fetch addresses.

Ports (the polarity and synchronicity of `Reset` are fixed):
- `Clock`, in, 1: single clock. All logic is on its rising edge.
- `Reset`, in, 1: synchronous, active-low.
- `iFetchReq`, in, 1: fetch request, sampled on the clock edge.
- `iAddress`, in, ADDR_WIDTH: fetch address.
- `oInstruction`, out, DATA_WIDTH: fetched word, registered.
- `oInstrValid`, out, 1: one-cycle pulse marking a valid `oInstruction`.
- `oParityErr`, out, 1: parity mismatch on the current fetch. Qualified by `oInstrValid`.
- `iLoadStart`, in, 1: begin a program load.
- `iLoadCount`, in, ADDR_WIDTH: number of words to load. Latched on `iLoadStart`.
- `iLoadValid`, in, 1: `iLoadData` is valid.
- `iLoadData`, in, DATA_WIDTH: word to write.
- `iParityFlip`, in, 1: inverts the stored parity bit of the current load write (test hook).
- `oLoadReady`, out, 1: block accepts a load word.
- `oLoadDone`, out, 1: one-cycle pulse when the load completes.
- `oBusy`, out, 1: high in LOAD and DONE.

## Operation
- FSM states: RUN, LOAD, DONE. Reset state is RUN.
- Reset values: `oInstruction`=DEFAULT_WORD; all 1-bit outputs 0; load pointer 0.
- Memory contents are not reset. They are undefined until loaded.
- RUN:
  - Transfer when `iFetchReq`=1: the next cycle `oInstruction`=mem[`iAddress`] and `oInstrValid`=1.
  - If `iAddress` ≥ DEPTH, the word returned is DEFAULT_WORD and `oParityErr`=0.
  - With no request, `oInstrValid`=0 and `oInstruction` holds its last value.
- RUN→LOAD on `iLoadStart`=1. That same-cycle fetch is dropped (no valid pulse).
- Count latching on entry to LOAD:
  - `iLoadCount` is latched and clamped to DEPTH.
  - Latched count 0 → go straight to DONE.
  - Pointer cleared to 0.
- LOAD:
  - `oLoadReady`=1.
  - Each cycle with `iLoadValid`=1, mem[ptr] is written and ptr increments.
  - The write of word count−1 moves to DONE.
  - Gaps (`iLoadValid`=0) are allowed and do not time out.
  - `iLoadStart` and `iFetchReq` are ignored in LOAD.
- DONE: `oLoadDone`=1 for one cycle, `oLoadReady`=0, then RUN.
- Reset mid-load returns to RUN with pointer 0. Words already written stay in memory.
- Arithmetic: the pointer is ADDR_WIDTH+1 bits wide, so it cannot wrap before the clamp applies.

## Timing
- Fetch latency: 1 cycle. A request at edge N gives the word and valid pulse after edge N, for cycle N+1.
- Back-to-back fetches give one word per cycle.
- Load throughput: 1 word per cycle. A write is visible to a fetch issued the cycle after DONE.
- `oLoadReady` depends only on state (registered). It never depends combinationally on `iLoadValid`.
- `oLoadDone` asserts the cycle after the final write is accepted.
- From that final write, a fetch request can be accepted 2 cycles later (the first RUN cycle).

## Configuration
- Macro: `INSTR_MEM_PARITY_EN`.
- Defined:
  - Each word is stored DATA_WIDTH+1 bits wide, with even parity computed at write (XOR-reduce of data, inverted when `iParityFlip`=1).
  - On fetch, parity is recomputed. `oParityErr`=1 with `oInstrValid` on mismatch.
  - Out-of-range addresses never flag an error.
- Undefined:
  - Storage is DATA_WIDTH bits.
  - `oParityErr` is tied to 0 and `iParityFlip` is ignored.
  - The port list is identical in both builds.

## Test plan
- Reset, then idle: all outputs 0 and `oInstruction`=DEFAULT_WORD. Assert `Reset`=0 mid-load after 3 of 8 words: FSM is RUN, `oBusy`=0, and words 0–2 are readable.
- Load 4 words (28'h1000000, 28'h2000001, 28'h3000002, 28'h4000003) with 1-cycle `iLoadValid` gaps:
  - `oLoadDone` pulses once, the cycle after the 4th write.
  - Then back-to-back fetches of 0..3 return those words, each 1 cycle after its request.
- Fetch at `iAddress`=DEPTH and 16'hFFFF → DEFAULT_WORD, `oInstrValid`=1, `oParityErr`=0.
- `iLoadCount`=0 → `oLoadDone` pulses one cycle after start with no writes. `iLoadCount`=DEPTH+10 → exactly DEPTH writes accepted, then DONE.
- `iLoadStart` and `iFetchReq` in the same cycle → no `oInstrValid` pulse, `oBusy`=1 next cycle. `iFetchReq` held during LOAD → no valid pulses.
- With `INSTR_MEM_PARITY_EN`, load word 2 with `iParityFlip`=1: fetch of address 2 gives `oParityErr`=1, fetch of address 1 gives 0. Without the macro, `oParityErr`=0 for both.
